line_raster_engine: RTL and testbench
=====================================

LINE_RASTER_ENGINE -- requirements
Module: line_raster_engine

Interface
REQ-001 SHALL have parameter COORD_W, default 10, coordinate width in bits.
REQ-002 SHALL have parameter ADDR_W, default 31, memory address width in bits.
REQ-003 SHALL have parameter COLOR_W, default 24, pixel colour width in bits, zero-extended to 32 bits per pixel.
REQ-004 SHALL have ports: clk input 1 (clock); rst_n input 1 (asynchronous, active-low reset); both fixed as one clock, async active-low reset.
REQ-005 SHALL have ports: cmd_valid input 1, command offered; cmd_ready output 1, command accepted when both high.
REQ-006 SHALL have ports: cmd_x0, cmd_y0, cmd_x1, cmd_y1 input COORD_W each, inclusive endpoints.
REQ-007 SHALL have ports: cmd_color input COLOR_W; cmd_base input ADDR_W, frame base address.
REQ-008 SHALL have ports: af_full input 1; wdf_full input 1; af_addr_din output ADDR_W; af_wr_en output 1.
REQ-009 SHALL have ports: wdf_din output 128; wdf_mask_din output 16, bit=1 masks byte; wdf_wr_en output 1.
REQ-010 SHALL have ports: busy output 1, not IDLE; line_done output 1, one-cycle completion pulse.

Function
REQ-011 SHALL implement states IDLE, SETUP, PLOT, BEAT0, BEAT1.
REQ-012 SHALL assert cmd_ready only in IDLE; acceptance latches all cmd_* fields and moves to SETUP.
REQ-013 SETUP (1 cycle) SHALL compute steep = |dy|>|dx|, swap x/y if steep, swap endpoints if x0>x1, deltax = x1-x0, abs_dy, ystep = +1 if y1>y0 else -1, err = floor(deltax/2); then PLOT.
REQ-014 err and deltas SHALL be signed COORD_W+2 bits; no overflow at COORD_W extremes.
REQ-015 PLOT (1 cycle) SHALL register row/col (row=y, col=x if !steep; row=x, col=y if steep), then BEAT0.
REQ-016 af_addr_din SHALL equal base + {row, col[COORD_W-1:3], 2'b00}, truncated to ADDR_W.
REQ-017 wdf_din SHALL be four copies of {zero pad, color}.
REQ-018 p = col[2:0]; BEAT0 SHALL unmask only nibble (3-p) for p<4 (p=0 -> 16'h0FFF), else 16'hFFFF; BEAT1 likewise for p-4.
REQ-019 In BEAT0, af_wr_en = wdf_wr_en = !af_full && !wdf_full; state holds until that transfer, then BEAT1.
REQ-020 In BEAT1, wdf_wr_en = !wdf_full; state holds until transfer.
REQ-021 On BEAT1 transfer: if x==x1, pulse line_done and go IDLE; else x+=1, err-=abs_dy, if err<0 then y+=ystep and err+=deltax; go PLOT.
REQ-022 af_wr_en and wdf_wr_en SHALL be 0 outside BEAT0/BEAT1; address never written without data.
REQ-023 Degenerate line (x0==x1, y0==y1) SHALL emit exactly one pixel.
REQ-024 Pixel count SHALL equal max(|dx|,|dy|)+1; endpoints inclusive.
REQ-025 Command arriving while busy SHALL not be accepted; cmd_ready low until IDLE.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, regardless of state, abandoning any line mid-operation.
REQ-027 Reset values: cmd_ready=0 while rst_n low, 1 after release; busy=0, line_done=0, af_wr_en=0, wdf_wr_en=0, af_addr_din=0, wdf_mask_din=16'hFFFF, wdf_din=0.
REQ-028 A line interrupted by reset SHALL not resume; partial writes are permitted.

Configuration
REQ-029 Macro LINE_RASTER_PATTERN_EN defined: port cmd_pattern input 16 is latched with the command; pixel i (0-based from the post-swap x0) is written only if cmd_pattern[i mod 16]==1; skipped pixels spend one PLOT cycle, do no FIFO writes, and still advance Bresenham.
REQ-030 Macro undefined: no cmd_pattern port; every pixel is written.
REQ-031 A line whose last pixel is skipped SHALL still pulse line_done on leaving PLOT.

Verification
REQ-032 Horizontal (0,0)->(7,0), color 24'hFF0000, base 0 -> 8 addr writes, all 0, 16 data beats, masks 0FFF,FFFF / F0FF,FFFF / ... / FFFF,FFF0; line_done once.
REQ-033 Steep (5,0)->(5,3) -> 4 pixels, addresses {row=y,col=5}: 0x0000+{y,7'd0,2'b0}, mask BEAT0 FFFF, BEAT1 F0FF each.
REQ-034 Reversed diagonal (3,3)->(0,0) -> pixels (0,0),(1,1),(2,2),(3,3) in that order.
REQ-035 af_full held high 10 cycles during BEAT0, wdf_full high 5 cycles in BEAT1 -> no enables asserted while full, no lost or duplicated beats.
REQ-036 rst_n low during BEAT1 of pixel 2 of a 6-pixel line -> same cycle enables 0, busy 0; after release cmd_ready 1, next line correct.
REQ-037 With LINE_RASTER_PATTERN_EN, pattern 16'h5555 on (0,0)->(15,0) -> 8 pixels written, x=0,2,...,14; line_done once.

Source files
------------

// File: rtl/line_raster_engine_if.sv
// ---------------------------------------------------------------------------
// line_raster_engine_if
//   Groups the command handshake, the address/write-data FIFO bus and the
//   status outputs of line_raster_engine.
//   Command side : cmd_valid/cmd_ready handshake, cmd_x0/y0/x1/y1 endpoints,
//                  cmd_color, cmd_base (and cmd_pattern when the macro
//                  LINE_RASTER_PATTERN_EN is defined).
//   Memory side  : af_full/af_addr_din/af_wr_en (address FIFO),
//                  wdf_full/wdf_din/wdf_mask_din/wdf_wr_en (data FIFO).
//   Status       : busy, line_done.
//   Modports     : master = command source / FIFO model, slave = engine.
// ---------------------------------------------------------------------------
interface line_raster_engine_if #(
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 31,
    parameter int COLOR_W = 24
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y1;
    logic [COLOR_W-1:0] cmd_color;
    logic [ADDR_W-1:0]  cmd_base;
`ifdef LINE_RASTER_PATTERN_EN
    logic [15:0]        cmd_pattern;
`endif
    logic               af_full;
    logic               wdf_full;
    logic [ADDR_W-1:0]  af_addr_din;
    logic               af_wr_en;
    logic [127:0]       wdf_din;
    logic [15:0]        wdf_mask_din;
    logic               wdf_wr_en;
    logic               busy;
    logic               line_done;

`ifdef LINE_RASTER_PATTERN_EN
    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_base,
               cmd_pattern, af_full, wdf_full,
        input  cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din,
               wdf_wr_en, busy, line_done
    );
    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_base,
               cmd_pattern, af_full, wdf_full,
        output cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din,
               wdf_wr_en, busy, line_done
    );
`else
    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_base,
               af_full, wdf_full,
        input  cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din,
               wdf_wr_en, busy, line_done
    );
    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_base,
               af_full, wdf_full,
        output cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din,
               wdf_wr_en, busy, line_done
    );
`endif
endinterface

// File: rtl/line_raster_engine.sv
// ---------------------------------------------------------------------------
// line_raster_engine
//   Bresenham line rasteriser. Accepts one line command at a time and writes
//   one pixel per address/data pair into a 128-bit memory FIFO interface
//   (one address beat + two 128-bit data beats covering 8 pixels of 32 bits).
//   Ports:
//     clk   - clock
//     rst_n - asynchronous active-low reset, forces IDLE immediately
//     bus   - line_raster_engine_if.slave (command, FIFO and status signals)
//   Optional feature: define LINE_RASTER_PATTERN_EN to add cmd_pattern, a
//   16-bit repeating stipple mask; pixels whose pattern bit is 0 are walked
//   but not written.
// ---------------------------------------------------------------------------
module line_raster_engine #(
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 31,
    parameter int COLOR_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    line_raster_engine_if.slave bus
);
    localparam int SW = COORD_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PLOT,
        S_BEAT0,
        S_BEAT1
    } state_t;

    state_t r_state, w_state_nxt;

    logic [COORD_W-1:0]   r_cx0, r_cy0, r_cx1, r_cy1;
    logic [COLOR_W-1:0]   r_color;
    logic [ADDR_W-1:0]    r_base;
    logic [COORD_W-1:0]   r_x, r_y, r_xend, r_row, r_col;
    logic signed [SW-1:0] r_err, r_dx, r_ady;
    logic                 r_steep, r_ydec;
`ifdef LINE_RASTER_PATTERN_EN
    logic [15:0]          r_pattern;
    logic [3:0]           r_idx;
`endif

    logic signed [SW-1:0] w_ddx, w_ddy, w_adx, w_ady0, w_deltax, w_dyb, w_abs_dy;
    logic signed [SW-1:0] w_err_sub, w_err_nxt;
    logic [COORD_W-1:0]   w_ax0, w_ay0, w_ax1, w_ay1, w_bx0, w_by0, w_bx1, w_by1;
    logic [COORD_W-1:0]   w_y_nxt;
    logic                 w_steep, w_swap, w_last, w_skip, w_step;
    logic                 w_af_we, w_wdf_we, w_done;
    logic [15:0]          w_mask, w_nib_mask;
    logic [2*COORD_W-2:0] w_addr_off;

    // Line setup: octant fold (steep swap, then left-to-right ordering)
    always_comb begin
        w_ddx    = SW'(r_cx1) - SW'(r_cx0);
        w_ddy    = SW'(r_cy1) - SW'(r_cy0);
        w_adx    = w_ddx[SW-1] ? -w_ddx : w_ddx;
        w_ady0   = w_ddy[SW-1] ? -w_ddy : w_ddy;
        w_steep  = w_ady0 > w_adx;
        w_ax0    = w_steep ? r_cy0 : r_cx0;
        w_ay0    = w_steep ? r_cx0 : r_cy0;
        w_ax1    = w_steep ? r_cy1 : r_cx1;
        w_ay1    = w_steep ? r_cx1 : r_cy1;
        w_swap   = w_ax0 > w_ax1;
        w_bx0    = w_swap ? w_ax1 : w_ax0;
        w_by0    = w_swap ? w_ay1 : w_ay0;
        w_bx1    = w_swap ? w_ax0 : w_ax1;
        w_by1    = w_swap ? w_ay0 : w_ay1;
        w_deltax = SW'(w_bx1) - SW'(w_bx0);
        w_dyb    = SW'(w_by1) - SW'(w_by0);
        w_abs_dy = w_dyb[SW-1] ? -w_dyb : w_dyb;
    end

    // Bresenham step
    always_comb begin
        w_err_sub = r_err - r_ady;
        w_err_nxt = w_err_sub[SW-1] ? w_err_sub + r_dx : w_err_sub;
        w_y_nxt   = r_y;
        if (w_err_sub[SW-1])
            w_y_nxt = r_ydec ? r_y - COORD_W'(1) : r_y + COORD_W'(1);
    end

    assign w_last = (r_x == r_xend);
`ifdef LINE_RASTER_PATTERN_EN
    assign w_skip = !r_pattern[r_idx];
`else
    assign w_skip = 1'b0;
`endif

    // Nibble of the 8-pixel block occupied by this pixel; col[2] picks the beat
    assign w_nib_mask = ~(16'hF000 >> {r_col[1:0], 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_af_we     = 1'b0;
        w_wdf_we    = 1'b0;
        w_done      = 1'b0;
        w_step      = 1'b0;
        w_mask      = 16'hFFFF;
        case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = S_PLOT;
            S_PLOT: begin
                if (w_skip) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (!r_col[2]) w_mask = w_nib_mask;
                w_af_we  = !bus.af_full && !bus.wdf_full;
                w_wdf_we = w_af_we;
                if (w_af_we) w_state_nxt = S_BEAT1;
            end
            S_BEAT1: begin
                if (r_col[2]) w_mask = w_nib_mask;
                w_wdf_we = !bus.wdf_full;
                if (w_wdf_we) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_PLOT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx0   <= '0;
            r_cy0   <= '0;
            r_cx1   <= '0;
            r_cy1   <= '0;
            r_color <= '0;
            r_base  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_xend  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_err   <= '0;
            r_dx    <= '0;
            r_ady   <= '0;
            r_steep <= 1'b0;
            r_ydec  <= 1'b0;
`ifdef LINE_RASTER_PATTERN_EN
            r_pattern <= '0;
            r_idx     <= '0;
`endif
        end else begin
            if (r_state == S_IDLE && bus.cmd_valid) begin
                r_cx0   <= bus.cmd_x0;
                r_cy0   <= bus.cmd_y0;
                r_cx1   <= bus.cmd_x1;
                r_cy1   <= bus.cmd_y1;
                r_color <= bus.cmd_color;
                r_base  <= bus.cmd_base;
`ifdef LINE_RASTER_PATTERN_EN
                r_pattern <= bus.cmd_pattern;
`endif
            end
            if (r_state == S_SETUP) begin
                r_x     <= w_bx0;
                r_y     <= w_by0;
                r_xend  <= w_bx1;
                r_dx    <= w_deltax;
                r_ady   <= w_abs_dy;
                r_err   <= w_deltax >>> 1;
                r_steep <= w_steep;
                r_ydec  <= !(w_by1 > w_by0);
`ifdef LINE_RASTER_PATTERN_EN
                r_idx   <= '0;
`endif
            end
            if (r_state == S_PLOT) begin
                r_row <= r_steep ? r_x : r_y;
                r_col <= r_steep ? r_y : r_x;
            end
            if (w_step && !w_last) begin
                r_x   <= r_x + COORD_W'(1);
                r_y   <= w_y_nxt;
                r_err <= w_err_nxt;
`ifdef LINE_RASTER_PATTERN_EN
                r_idx <= r_idx + 4'd1;
`endif
            end
        end
    end

    assign w_addr_off       = {r_row, r_col[COORD_W-1:3], 2'b00};
    assign bus.af_addr_din  = r_base + ADDR_W'(w_addr_off);
    assign bus.wdf_din      = {4{32'(r_color)}};
    assign bus.wdf_mask_din = w_mask;
    assign bus.af_wr_en     = w_af_we;
    assign bus.wdf_wr_en    = w_wdf_we;
    assign bus.line_done    = w_done;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.cmd_ready    = (r_state == S_IDLE) && rst_n;
endmodule

// File: tb/tb_line_raster_engine.sv
// ---------------------------------------------------------------------------
// tb_line_raster_engine
//   Directed bench for line_raster_engine. Expected address and data beats
//   are queued when each line is issued and checked as the engine writes.
//   Define LINE_RASTER_PATTERN_EN to also exercise the stipple pattern.
// ---------------------------------------------------------------------------
module tb_line_raster_engine;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    line_raster_engine_if #(.COORD_W(10), .ADDR_W(31), .COLOR_W(24)) bus ();

    line_raster_engine #(.COORD_W(10), .ADDR_W(31), .COLOR_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    int n_beats  = 0;

    logic [30:0]  q_addr[$];
    logic [143:0] q_data[$];
    logic [30:0]  mon_ea;
    logic [143:0] mon_ed;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the writes one pixel (row, col) should produce
    task automatic push_pixel(input int row, input int col, input logic [23:0] color,
                              input logic [30:0] base, input bit full_px);
        logic [9:0]   r;
        logic [9:0]   c;
        logic [15:0]  m0;
        logic [15:0]  m1;
        logic [127:0] d;
        int           p;
        r  = row[9:0];
        c  = col[9:0];
        q_addr.push_back(base + 31'({r, c[9:3], 2'b00}));
        p  = col % 8;
        m0 = 16'hFFFF;
        m1 = 16'hFFFF;
        if (p < 4) m0[15-4*p -: 4] = 4'h0;
        else       m1[15-4*(p-4) -: 4] = 4'h0;
        d  = {4{8'h00, color}};
        q_data.push_back({m0, d});
        if (full_px) q_data.push_back({m1, d});
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [23:0] color, input logic [30:0] base);
        int k;
        bus.cmd_x0    = x0[9:0];
        bus.cmd_y0    = y0[9:0];
        bus.cmd_x1    = x1[9:0];
        bus.cmd_y1    = y1[9:0];
        bus.cmd_color = color;
        bus.cmd_base  = base;
        bus.cmd_valid = 1'b1;
        k = 0;
        while (!bus.cmd_ready && k < 100) begin
            tick();
            k++;
        end
        check("cmd_accept_timeout", 128'(k < 100), 128'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while ((n_done < target || bus.busy) && k < 2000) begin
            tick();
            k++;
        end
        check("line_done_count", 128'(n_done), 128'(target));
        check("idle_after_line", 128'(bus.busy), 128'd0);
        check("addr_queue_drained", 128'(q_addr.size()), 128'd0);
        check("data_queue_drained", 128'(q_data.size()), 128'd0);
    endtask

    // Write monitor: sampled mid-cycle, when FIFO enables are stable
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.af_full)  check("af_en_while_af_full", 128'(bus.af_wr_en), 128'd0);
            if (bus.wdf_full) check("wdf_en_while_wdf_full", 128'(bus.wdf_wr_en), 128'd0);
            if (bus.af_wr_en) begin
                check("addr_has_data", 128'(bus.wdf_wr_en), 128'd1);
                if (q_addr.size() == 0) begin
                    check("addr_unexpected", 128'(bus.af_addr_din), 128'h0 - 128'd1);
                end else begin
                    mon_ea = q_addr.pop_front();
                    check("af_addr_din", 128'(bus.af_addr_din), 128'(mon_ea));
                end
            end
            if (bus.wdf_wr_en) begin
                n_beats++;
                if (q_data.size() == 0) begin
                    check("beat_unexpected", 128'(bus.wdf_mask_din), 128'h0 - 128'd1);
                end else begin
                    mon_ed = q_data.pop_front();
                    check("wdf_mask_din", 128'(bus.wdf_mask_din), 128'(mon_ed[143:128]));
                    check("wdf_din", bus.wdf_din, mon_ed[127:0]);
                end
            end
            if (bus.line_done) n_done++;
        end
    end

    int t4x[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int t4y[10] = '{3, 3, 2, 2, 2, 1, 1, 1, 0, 0};

    initial begin
        int k;
        int nb0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_color = '0;
        bus.cmd_base  = '0;
        bus.af_full   = 1'b0;
        bus.wdf_full  = 1'b0;
`ifdef LINE_RASTER_PATTERN_EN
        bus.cmd_pattern = 16'hFFFF;
`endif

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_line_done", 128'(bus.line_done), 128'd0);
        check("rst_af_wr_en", 128'(bus.af_wr_en), 128'd0);
        check("rst_wdf_wr_en", 128'(bus.wdf_wr_en), 128'd0);
        check("rst_af_addr_din", 128'(bus.af_addr_din), 128'd0);
        check("rst_wdf_mask_din", 128'(bus.wdf_mask_din), 128'hFFFF);
        check("rst_wdf_din", bus.wdf_din, 128'd0);
        rst_n = 1'b1;
        #1;
        check("cmd_ready_after_rst", 128'(bus.cmd_ready), 128'd1);
        tick();

        // Horizontal (0,0)->(7,0); a second command offered while busy
        for (int c = 0; c < 8; c++) push_pixel(0, c, 24'hFF0000, 31'h0, 1'b1);
        send_cmd(0, 0, 7, 0, 24'hFF0000, 31'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_x1    = 10'd9;
        for (int i = 0; i < 3; i++) begin
            check("busy_cmd_ready", 128'(bus.cmd_ready), 128'd0);
            check("busy_flag", 128'(bus.busy), 128'd1);
            tick();
        end
        bus.cmd_valid = 1'b0;
        wait_done(1);

        // Steep (5,0)->(5,3)
        for (int y = 0; y < 4; y++) push_pixel(y, 5, 24'h00FF00, 31'h0, 1'b1);
        send_cmd(5, 0, 5, 3, 24'h00FF00, 31'h0);
        wait_done(2);

        // Reversed diagonal (3,3)->(0,0), non-zero base
        for (int i = 0; i < 4; i++) push_pixel(i, i, 24'h0000FF, 31'h0100_0000, 1'b1);
        send_cmd(3, 3, 0, 0, 24'h0000FF, 31'h0100_0000);
        wait_done(3);

        // Shallow descending (0,3)->(9,0) with FIFO back-pressure
        for (int i = 0; i < 10; i++) push_pixel(t4y[i], t4x[i], 24'h00A5C3, 31'h0000_0100, 1'b1);
        send_cmd(0, 3, 9, 0, 24'h00A5C3, 31'h0000_0100);
        k = 0;
        while (!bus.af_wr_en && k < 100) begin
            tick();
            k++;
        end
        check("bp_beat0_seen", 128'(bus.af_wr_en), 128'd1);
        bus.af_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_af_full_wdf_en", 128'(bus.wdf_wr_en), 128'd0);
            tick();
        end
        bus.af_full = 1'b0;
        k = 0;
        while (!(bus.wdf_wr_en && !bus.af_wr_en) && k < 100) begin
            tick();
            k++;
        end
        check("bp_beat1_seen", 128'(bus.wdf_wr_en && !bus.af_wr_en), 128'd1);
        bus.wdf_full = 1'b1;
        repeat (5) tick();
        bus.wdf_full = 1'b0;
        wait_done(4);

        // Reset during BEAT1 of pixel 2 of (0,1)->(5,1)
        push_pixel(1, 0, 24'h123456, 31'h0, 1'b1);
        push_pixel(1, 1, 24'h123456, 31'h0, 1'b1);
        push_pixel(1, 2, 24'h123456, 31'h0, 1'b0);
        nb0 = n_beats;
        send_cmd(0, 1, 5, 1, 24'h123456, 31'h0);
        k = 0;
        while (!(n_beats == nb0 + 5 && bus.wdf_wr_en && !bus.af_wr_en) && k < 200) begin
            tick();
            k++;
        end
        check("abort_point_seen", 128'(k < 200), 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_af_wr_en", 128'(bus.af_wr_en), 128'd0);
        check("abort_wdf_wr_en", 128'(bus.wdf_wr_en), 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("abort_ready_after", 128'(bus.cmd_ready), 128'd1);
        check("abort_done_count", 128'(n_done), 128'd4);
        check("abort_addr_queue", 128'(q_addr.size()), 128'd0);
        check("abort_data_queue", 128'(q_data.size()), 128'd0);
        tick();

        // Degenerate single-pixel line after the abort
        push_pixel(2, 2, 24'h00CAFE, 31'h0, 1'b1);
        send_cmd(2, 2, 2, 2, 24'h00CAFE, 31'h0);
        wait_done(5);

`ifdef LINE_RASTER_PATTERN_EN
        // Stipple 0x5555 on (0,0)->(15,0): even x only, last pixel skipped
        for (int c = 0; c < 16; c += 2) push_pixel(0, c, 24'hABCDEF, 31'h0, 1'b1);
        bus.cmd_pattern = 16'h5555;
        send_cmd(0, 0, 15, 0, 24'hABCDEF, 31'h0);
        wait_done(6);
        bus.cmd_pattern = 16'hFFFF;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
